// File: rtl/stepper_motion_ctrl.sv
// Trapezoidal step-rate generator for one stepper channel.
// It takes a signed relative move and emits step pulses with a direction
// level. The step interval ramps linearly from PERIOD_MAX down to
// PERIOD_MIN, then back up so that the move ends at the start speed.
// It also keeps the absolute step position.
module stepper_motion_ctrl #(
    parameter int STEP_W     = 16,
    parameter int POS_W      = 32,
    parameter int PER_W      = 20,
    parameter int PERIOD_MAX = 50000,
    parameter int PERIOD_MIN = 5000,
    parameter int ACCEL_STEP = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [STEP_W-1:0] cmd_steps,
    input  logic                    abort,
    input  logic                    pos_zero,
    output logic                    step_en,
    output logic                    dir,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0]  position
);

    typedef enum logic {IDLE, MOVE} state_t;

    localparam logic [PER_W-1:0] P_MAX   = PER_W'(PERIOD_MAX);
    localparam logic [PER_W-1:0] P_MAX_1 = PER_W'(PERIOD_MAX - 1);
    // Widened by one bit so the ramp arithmetic can never wrap.
    localparam logic [PER_W:0]   P_MAXW  = (PER_W+1)'(PERIOD_MAX);
    localparam logic [PER_W:0]   ACC_W   = (PER_W+1)'(ACCEL_STEP);
    localparam logic [PER_W:0]   ACC_MIN = (PER_W+1)'(PERIOD_MIN + ACCEL_STEP);

    state_t              state_q, state_d;
    logic [PER_W-1:0]    timer_q, timer_d;
    logic [PER_W-1:0]    period_q, period_d;
    logic [STEP_W:0]     ramp_q, ramp_d;
    logic [STEP_W:0]     remaining_q, remaining_d;
    logic                dir_q, dir_d;
    logic                done_q, done_d;
    logic [POS_W-1:0]    position_q, position_d;

    logic signed [STEP_W:0] cmd_ext;
    logic [STEP_W:0]        cmd_abs;
    logic [STEP_W:0]        rem_dec;
    logic [PER_W:0]         per_up;
    logic [PER_W-1:0]       per_next;
    logic                   step_fire;

    // Next-state, ramp schedule and position update.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        period_d    = period_q;
        ramp_d      = ramp_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        position_d  = position_q;
        per_next    = period_q;

        // Sign-extend by one bit so the magnitude of the most negative count fits.
        cmd_ext = {cmd_steps[STEP_W-1], cmd_steps};
        cmd_abs = cmd_steps[STEP_W-1] ? unsigned'(-cmd_ext) : unsigned'(cmd_ext);
        rem_dec = remaining_q - 1'b1;
        per_up  = {1'b0, period_q} + ACC_W;

        // An abort in the same cycle suppresses the step that was due.
        step_fire = (state_q == MOVE) && (timer_q == '0) && !abort;

        unique case (state_q)
            IDLE: begin
                if (pos_zero) position_d = '0;
                if (cmd_valid) begin
                    dir_d       = !cmd_steps[STEP_W-1];
                    remaining_d = cmd_abs;
                    period_d    = P_MAX;
                    ramp_d      = '0;
                    timer_d     = P_MAX_1;
                    if (cmd_abs == '0) done_d  = 1'b1;
                    else               state_d = MOVE;
                end
            end
            MOVE: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == '0) begin
                    position_d = position_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
                    if (rem_dec == '0) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        remaining_d = rem_dec;
                        // Start slowing once the steps left equal the steps spent speeding up.
                        if (rem_dec <= ramp_q) begin
                            per_next = (per_up > P_MAXW) ? P_MAX : per_up[PER_W-1:0];
                            ramp_d   = ramp_q - 1'b1;
                        end else if ({1'b0, period_q} >= ACC_MIN) begin
                            per_next = period_q - ACC_W[PER_W-1:0];
                            ramp_d   = ramp_q + 1'b1;
                        end
                        period_d = per_next;
                        timer_d  = per_next - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            period_q    <= P_MAX;
            ramp_q      <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b1;
            done_q      <= 1'b0;
            position_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            ramp_q      <= ramp_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            position_q  <= position_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == MOVE);
    assign step_en   = step_fire;
    assign dir       = dir_q;
    assign done      = done_q;
    assign position  = signed'(position_q);

endmodule
